ps2_host_tx: RTL

- Host-to-device transmitter for the PS/2 keyboard port, complementing the existing PS/2 receive path.
- Sends one command byte per request to the keyboard, e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable.
- Drives the open-drain clock/data lines through enable outputs, and signals the receive path to ignore line activity during a transfer.
- Sits beside the PS/2 receiver inside the keyboard device; the pad-level tristate lives at the top level.

---
 rtl/ps2_host_tx_pkg.sv | 25 ++
 rtl/ps2_line_cond.sv | 52 +++++
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding, frame
// geometry, common keyboard command bytes and the frame builder.
package ps2_host_tx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam int FRAME_LEN = 11;
    localparam int HOST_BITS = FRAME_LEN - 1;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;

    // Host-side bits in shift order: data LSB first, odd parity, stop.
    function automatic logic [HOST_BITS-1:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// PS/2 line conditioning: 2-FF synchronizers on clock and data, a clock
// glitch filter and a one-cycle falling-edge pulse. Shared with the receiver.
module ps2_line_cond #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_filt,
    output logic o_data_sync,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(FILTER_CYCLES - 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Idle bus is high, so synchronizers and filter come out of reset at 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_fall      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_fall      <= 1'b0;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_cnt      <= '0;
                r_clk_filt <= r_clk_sync[1];
                r_fall     <= ~r_clk_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_clk_filt  = r_clk_filt;
    assign o_data_sync = r_data_sync[1];
    assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain enables.
// Define PS2_TX_RETRY_EN to retry NACK/timeout failures up to RETRY_MAX times.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int RETRY_MAX      = 3
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'(HOST_BITS - 1);
`ifdef PS2_TX_RETRY_EN
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
    logic [RW-1:0] r_retry;
`endif

    logic [2:0]           r_state;
    logic [HOST_BITS-1:0] r_frame;
    logic [3:0]           r_bitcnt;
    logic [IW-1:0]        r_inh_cnt;
    logic [TW-1:0]        r_to_cnt;
    logic                 r_data_oe;
    logic                 r_done;
    logic                 r_err;

    logic w_clk_filt;
    logic w_data_s;
    logic w_fall;
    logic w_inh_last;
    logic w_fail;

    ps2_line_cond #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_line_cond (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_ps2_clk  (ps2_clk_i),
        .i_ps2_data (ps2_data_i),
        .o_clk_filt (w_clk_filt),
        .o_data_sync(w_data_s),
        .o_fall     (w_fall)
    );

    assign w_inh_last = (r_inh_cnt == INH_LAST);
    // Only evaluated in the timed states REQ..WAIT_IDLE.
    assign w_fail = (r_to_cnt == TO_LAST) || ((r_state == ST_ACK) && w_fall && w_data_s);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_bitcnt  <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_en) begin
                        r_frame   <= make_frame(tx_data);
                        r_inh_cnt <= '0;
                        r_state   <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        r_retry   <= '0;
`endif
                    end
                end
                ST_INHIBIT: begin
                    if (w_inh_last) begin
                        r_data_oe <= 1'b1;
                        r_to_cnt  <= '0;
                        r_bitcnt  <= '0;
                        r_state   <= ST_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + IW'(1);
                    end
                end
                ST_REQ, ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
                    if (r_to_cnt != TO_LAST) begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                    if (w_fail) begin
                        r_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                        if (r_retry != RETRY_LAST) begin
                            r_retry   <= r_retry + RW'(1);
                            r_inh_cnt <= '0;
                            r_state   <= ST_INHIBIT;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
`else
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end else if (r_state == ST_WAIT_IDLE) begin
                        if (w_clk_filt && w_data_s) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_fall) begin
                        if (r_state == ST_ACK) begin
                            r_state <= ST_WAIT_IDLE;
                        end else begin
                            r_data_oe <= ~r_frame[r_bitcnt];
                            r_bitcnt  <= r_bitcnt + 4'd1;
                            r_state   <= (r_bitcnt == LAST_BIT) ? ST_ACK : ST_DATA;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Start bit overlaps the last inhibit cycle so data is low before clock is released.
    assign ps2_clk_oe  = (r_state == ST_INHIBIT);
    assign ps2_data_oe = r_data_oe || ((r_state == ST_INHIBIT) && w_inh_last);
    assign busy        = (r_state != ST_IDLE);
    assign rx_inhibit  = busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule
